rs_age_ordered: RTL
===================

Name: rs_age_ordered

Overview:
- Parametrised reservation station, next generation of the ALU-side RS.
- Sits between decoder and ALU. Holds renamed ALU instructions until both operands are available.
- Wakes operands from N_CDB result broadcast channels, including a same-cycle bypass on insert.
- Issues the oldest ready entry. Honours ALU back-pressure and flushes on rollback.

Parameters:
RS_DEPTH, 16, number of entries (power of two, >=2)
N_CDB, 2, number of result broadcast channels (ALU, LSB, ...)
DATA_W, 32, operand/imm/off/pc width
ROB_ID_W, 4, ROB tag width
OPCODE_W, 7, opcode width
FUNC3_W, 3, func3 width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
rollback  in  1  mispredict flush, synchronous
rs_full  out  1  free entries <= 1 (combinational from current state)
rs_count  out  $clog2(RS_DEPTH)+1  occupied entries
inst_valid  in  1  decoder insert request
inst_opcode / inst_func3 / inst_func1  in  OPCODE_W / FUNC3_W / 1  op fields
inst_reg1_depend_rob, inst_reg1_data, inst_reg1_rob_id  in  1 / DATA_W / ROB_ID_W  operand 1
inst_reg2_depend_rob, inst_reg2_data, inst_reg2_rob_id  in  1 / DATA_W / ROB_ID_W  operand 2
inst_rd_rob_id  in  ROB_ID_W  destination tag
inst_imm / inst_off / inst_pc  in  DATA_W each
cdb_valid  in  N_CDB  per-channel broadcast valid
cdb_rob_id  in  N_CDB*ROB_ID_W  packed tags, channel k at [k*ROB_ID_W +: ROB_ID_W]
cdb_data  in  N_CDB*DATA_W  packed results
exe_ready  in  1  ALU accepts the current exe bundle
exe_valid  out  1  issue bundle valid (registered)
exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2, exe_imm, exe_off, exe_pc, exe_rob_target  out  matching widths  issue bundle

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high. Priority order: rst/rollback, then rdy, then normal operation.
- Reset/rollback:
  - All entries become free; age state clears.
  - exe_valid=0; all exe_* =0; rs_count=0; rs_full=0.
  - A rollback in the same cycle as inst_valid discards the insert.
- rdy=0: no state change. Outputs hold their values.
- Insert:
  - When inst_valid, the bundle is written into the lowest-index free entry of the current state.
  - The entry becomes the youngest in age order.
  - inst_valid with zero free entries is a protocol violation. Nothing is written; the bench flags it.
  - Decoder stalls on rs_full. This gives one cycle of slack for the registered decode.
- Insert bypass: if inst_regX_depend_rob=1 and any cdb_valid[k] has a matching tag this cycle, the entry stores cdb_data[k] with depend cleared.
- Wakeup:
  - Every busy entry with depend=1 and a matching tag on any valid channel captures the data and clears depend at the edge.
  - Both operands may wake in the same cycle from different channels.
  - Duplicate tags across channels are illegal; the lowest k wins.
- Ready: busy and both depend=0, evaluated on registered state. Woken entries become eligible the following cycle.
- Issue:
  - Issue is allowed when !exe_valid || exe_ready.
  - If allowed and any entry is ready, the oldest ready entry is loaded into exe_*. exe_valid=1 next cycle and the entry is freed at the same edge.
  - If allowed and no entry is ready, exe_valid<=0.
  - If exe_valid && !exe_ready, exe_* and exe_valid hold and no entry is freed.
- Age:
  - RS_DEPTH x RS_DEPTH older-than matrix. Insert sets row/column so the new entry is younger than all busy entries.
  - The oldest ready entry is the one with no ready entry older than it.
- Concurrency:
  - Insert, issue and wakeup in the same cycle are all applied.
  - The issued entry is distinct from the inserted entry.
  - rs_count += insert − issue.
- Latency: insert-to-exe_valid is 2 edges minimum with operands ready. With a CDB bypass on insert it is also 2.

Decomposition:
- const.v gains RS_DEPTH, N_CDB, ROB_ID_W and DATA_W defaults as `define, shared with ROB/LSB.
- One sub-module, rs_age_picker: takes the ready vector and age matrix, outputs a one-hot oldest entry plus a found flag. It is purely combinational and reused by the future LSB.

Test Plan:
- Reset, then insert 3 ready ADDs (rob 1,2,3) on consecutive cycles with exe_ready=1 -> exe_valid on cycles 2,3,4 with exe_rob_target 1,2,3.
- Insert A (rob5, depends rob9), then B (rob6, ready). Broadcast rob9=0x1234 on cdb[1] -> B issues first, then A with exe_data1=0x1234.
- Insert with reg2 depending on rob7 while cdb[0] broadcasts rob7=0xDEAD in the same cycle -> issues 2 edges later with exe_data2=0xDEAD.
- Hold exe_ready=0 for 4 cycles with 2 ready entries -> exe_* stable, rs_count stays 2. Release -> both issue in age order on consecutive cycles.
- Fill to RS_DEPTH-1 entries -> rs_full=1, rs_count=15. One issue -> rs_full=0.
- Assert rollback with 5 busy entries, exe_valid=1 and inst_valid=1 -> next cycle rs_count=0, exe_valid=0, no later issue of the flushed tags.

Source files
------------

// File: rtl/rs_age_ordered_pkg.sv
// Shared defaults for the age-ordered reservation station and its picker.
// The ROB and LSB use the same tag/data widths, so they live here once.
package rs_age_ordered_pkg;

  localparam int RS_DEPTH_DEF = 16;
  localparam int N_CDB_DEF    = 2;
  localparam int DATA_W_DEF   = 32;
  localparam int ROB_ID_W_DEF = 4;
  localparam int OPCODE_W_DEF = 7;
  localparam int FUNC3_W_DEF  = 3;

  // Width of an occupancy counter that can hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rs_age_picker.sv
// Oldest-ready selector over an older-than matrix.
// older_i[i][j] = 1 means entry j is older than entry i. The winner is the
// ready entry that has no ready entry older than itself. Purely combinational.
module rs_age_picker
  import rs_age_ordered_pkg::*;
#(
  parameter int N = RS_DEPTH_DEF
) (
  input  logic [N-1:0]        ready_i,
  input  logic [N-1:0][N-1:0] older_i,
  output logic [N-1:0]        pick_o,
  output logic                found_o
);

  // Entry wins when it is ready and no ready entry is older.
  always_comb begin
    pick_o = '0;
    for (int i = 0; i < N; i++) begin
      pick_o[i] = ready_i[i] & ~(|(older_i[i] & ready_i));
    end
  end

  assign found_o = |ready_i;

endmodule

// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station for the ALU. Holds renamed instructions
// until both operands are known, wakes them from the result broadcast
// channels (with bypass on insert) and issues the oldest ready entry.
module rs_age_ordered
  import rs_age_ordered_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int N_CDB    = N_CDB_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ROB_ID_W = ROB_ID_W_DEF,
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int FUNC3_W  = FUNC3_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        rollback,
  output logic                        rs_full,
  output logic [$clog2(RS_DEPTH):0]   rs_count,
  input  logic                        inst_valid,
  input  logic [OPCODE_W-1:0]         inst_opcode,
  input  logic [FUNC3_W-1:0]          inst_func3,
  input  logic                        inst_func1,
  input  logic                        inst_reg1_depend_rob,
  input  logic [DATA_W-1:0]           inst_reg1_data,
  input  logic [ROB_ID_W-1:0]         inst_reg1_rob_id,
  input  logic                        inst_reg2_depend_rob,
  input  logic [DATA_W-1:0]           inst_reg2_data,
  input  logic [ROB_ID_W-1:0]         inst_reg2_rob_id,
  input  logic [ROB_ID_W-1:0]         inst_rd_rob_id,
  input  logic [DATA_W-1:0]           inst_imm,
  input  logic [DATA_W-1:0]           inst_off,
  input  logic [DATA_W-1:0]           inst_pc,
  input  logic [N_CDB-1:0]            cdb_valid,
  input  logic [N_CDB*ROB_ID_W-1:0]   cdb_rob_id,
  input  logic [N_CDB*DATA_W-1:0]     cdb_data,
  input  logic                        exe_ready,
  output logic                        exe_valid,
  output logic [OPCODE_W-1:0]         exe_opcode,
  output logic [FUNC3_W-1:0]          exe_func3,
  output logic                        exe_func1,
  output logic [DATA_W-1:0]           exe_data1,
  output logic [DATA_W-1:0]           exe_data2,
  output logic [DATA_W-1:0]           exe_imm,
  output logic [DATA_W-1:0]           exe_off,
  output logic [DATA_W-1:0]           exe_pc,
  output logic [ROB_ID_W-1:0]         exe_rob_target
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = cnt_w(RS_DEPTH);

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC3_W-1:0]  func3;
    logic                func1;
    logic                dep1;
    logic [ROB_ID_W-1:0] tag1;
    logic [DATA_W-1:0]   data1;
    logic                dep2;
    logic [ROB_ID_W-1:0] tag2;
    logic [DATA_W-1:0]   data2;
    logic [ROB_ID_W-1:0] rd;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   off;
    logic [DATA_W-1:0]   pc;
  } entry_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC3_W-1:0]  func3;
    logic                func1;
    logic [DATA_W-1:0]   data1;
    logic [DATA_W-1:0]   data2;
    logic [ROB_ID_W-1:0] rd;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   off;
    logic [DATA_W-1:0]   pc;
  } issue_t;

  entry_t                             ent_q [RS_DEPTH];
  entry_t                             ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0]                busy_q, busy_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  older_q, older_d;
  issue_t                             exe_q, exe_d;
  logic                               exe_valid_q, exe_valid_d;
  logic [CNT_W-1:0]                   count_q, count_d;

  logic [RS_DEPTH-1:0] ready_s;
  logic [RS_DEPTH-1:0] pick_s;
  logic                found_s;
  issue_t              issue_pick_s;
  logic                free_found_s;
  logic [IDX_W-1:0]    ins_idx_s;
  entry_t              ins_ent_s;
  logic                issue_en_s;
  logic                ins_s;
  logic                iss_s;

  // Ready vector from registered state: busy with both operands known.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_s[i] = busy_q[i] & ~ent_q[i].dep1 & ~ent_q[i].dep2;
    end
  end

  rs_age_picker #(.N(RS_DEPTH)) u_picker (
    .ready_i (ready_s),
    .older_i (older_q),
    .pick_o  (pick_s),
    .found_o (found_s)
  );

  // Mux the one-hot winner into an issue bundle.
  always_comb begin
    issue_pick_s = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (pick_s[i]) begin
        issue_pick_s.opcode = ent_q[i].opcode;
        issue_pick_s.func3  = ent_q[i].func3;
        issue_pick_s.func1  = ent_q[i].func1;
        issue_pick_s.data1  = ent_q[i].data1;
        issue_pick_s.data2  = ent_q[i].data2;
        issue_pick_s.rd     = ent_q[i].rd;
        issue_pick_s.imm    = ent_q[i].imm;
        issue_pick_s.off    = ent_q[i].off;
        issue_pick_s.pc     = ent_q[i].pc;
      end else begin
        issue_pick_s = issue_pick_s;
      end
    end
  end

  // Lowest-index free slot of the current state (descending scan, last hit wins).
  always_comb begin
    free_found_s = 1'b0;
    ins_idx_s    = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found_s = 1'b1;
        ins_idx_s    = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Build the inserted entry, capturing same-cycle broadcasts; lowest channel wins.
  always_comb begin
    ins_ent_s        = '0;
    ins_ent_s.opcode = inst_opcode;
    ins_ent_s.func3  = inst_func3;
    ins_ent_s.func1  = inst_func1;
    ins_ent_s.dep1   = inst_reg1_depend_rob;
    ins_ent_s.tag1   = inst_reg1_rob_id;
    ins_ent_s.data1  = inst_reg1_data;
    ins_ent_s.dep2   = inst_reg2_depend_rob;
    ins_ent_s.tag2   = inst_reg2_rob_id;
    ins_ent_s.data2  = inst_reg2_data;
    ins_ent_s.rd     = inst_rd_rob_id;
    ins_ent_s.imm    = inst_imm;
    ins_ent_s.off    = inst_off;
    ins_ent_s.pc     = inst_pc;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (inst_reg1_depend_rob && cdb_valid[k] &&
          cdb_rob_id[k*ROB_ID_W +: ROB_ID_W] == inst_reg1_rob_id) begin
        ins_ent_s.data1 = cdb_data[k*DATA_W +: DATA_W];
        ins_ent_s.dep1  = 1'b0;
      end else begin
        ins_ent_s.dep1  = ins_ent_s.dep1;
      end
      if (inst_reg2_depend_rob && cdb_valid[k] &&
          cdb_rob_id[k*ROB_ID_W +: ROB_ID_W] == inst_reg2_rob_id) begin
        ins_ent_s.data2 = cdb_data[k*DATA_W +: DATA_W];
        ins_ent_s.dep2  = 1'b0;
      end else begin
        ins_ent_s.dep2  = ins_ent_s.dep2;
      end
    end
  end

  assign issue_en_s = ~exe_valid_q | exe_ready;

  // Next state: flush, then freeze on !rdy, else wakeup + issue + insert together.
  always_comb begin
    ent_d       = ent_q;
    busy_d      = busy_q;
    older_d     = older_q;
    exe_d       = exe_q;
    exe_valid_d = exe_valid_q;
    count_d     = count_q;
    ins_s       = 1'b0;
    iss_s       = 1'b0;
    if (rollback) begin
      busy_d      = '0;
      older_d     = '0;
      exe_d       = '0;
      exe_valid_d = 1'b0;
      count_d     = '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        for (int k = N_CDB - 1; k >= 0; k--) begin
          if (busy_q[i] && ent_q[i].dep1 && cdb_valid[k] &&
              cdb_rob_id[k*ROB_ID_W +: ROB_ID_W] == ent_q[i].tag1) begin
            ent_d[i].data1 = cdb_data[k*DATA_W +: DATA_W];
            ent_d[i].dep1  = 1'b0;
          end else begin
            ent_d[i].dep1  = ent_d[i].dep1;
          end
          if (busy_q[i] && ent_q[i].dep2 && cdb_valid[k] &&
              cdb_rob_id[k*ROB_ID_W +: ROB_ID_W] == ent_q[i].tag2) begin
            ent_d[i].data2 = cdb_data[k*DATA_W +: DATA_W];
            ent_d[i].dep2  = 1'b0;
          end else begin
            ent_d[i].dep2  = ent_d[i].dep2;
          end
        end
      end
      if (issue_en_s) begin
        if (found_s) begin
          exe_d       = issue_pick_s;
          exe_valid_d = 1'b1;
          busy_d      = busy_d & ~pick_s;
          iss_s       = 1'b1;
        end else begin
          exe_valid_d = 1'b0;
        end
      end else begin
        exe_valid_d = exe_valid_q;
      end
      // New entry is younger than every currently busy entry.
      if (inst_valid && free_found_s) begin
        ent_d[ins_idx_s]   = ins_ent_s;
        busy_d[ins_idx_s]  = 1'b1;
        older_d[ins_idx_s] = busy_q;
        for (int r = 0; r < RS_DEPTH; r++) begin
          older_d[r][ins_idx_s] = 1'b0;
        end
        ins_s = 1'b1;
      end else begin
        ins_s = 1'b0;
      end
      count_d = count_q + CNT_W'(ins_s) - CNT_W'(iss_s);
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      older_q     <= '0;
      exe_q       <= '0;
      exe_valid_q <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      older_q     <= older_d;
      exe_q       <= exe_d;
      exe_valid_q <= exe_valid_d;
      count_q     <= count_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign rs_full        = (count_q >= CNT_W'(RS_DEPTH - 1));
  assign rs_count       = count_q;
  assign exe_valid      = exe_valid_q;
  assign exe_opcode     = exe_q.opcode;
  assign exe_func3      = exe_q.func3;
  assign exe_func1      = exe_q.func1;
  assign exe_data1      = exe_q.data1;
  assign exe_data2      = exe_q.data2;
  assign exe_imm        = exe_q.imm;
  assign exe_off        = exe_q.off;
  assign exe_pc         = exe_q.pc;
  assign exe_rob_target = exe_q.rd;

endmodule
